// File: rtl/coin_acceptor_if.sv
// Coin slot sensors and downstream hold in, issued coin code and status pulses out.
// master drives the sensors and hold; slave is the acceptor.
interface coin_acceptor_if;
  logic       sense_5;
  logic       sense_10;
  logic       hold;
  logic [1:0] coin;
  logic       reject;
  logic       overflow;
  logic       fifo_full;

  modport master (
    output sense_5, sense_10, hold,
    input  coin, reject, overflow, fifo_full
  );

  modport slave (
    input  sense_5, sense_10, hold,
    output coin, reject, overflow, fifo_full
  );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronises and debounces two coin sensors, queues one code per debounced rising edge, and issues
// each as a one-cycle code DEBOUNCE_CYCLES+4 edges after insert; hold stalls issue while the FIFO absorbs coins.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic            clk,
  input  logic            rst,
  coin_acceptor_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // bit 0 is the 5-rupee slot, bit 1 the 10-rupee slot
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, stable, rise;
  logic [CW-1:0] cnt [2];

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    coin_q;
  logic          reject_q, overflow_q;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;

  logic          can_issue, pop, push, full_now, single, both;
  logic [1:0]    push_code;

  assign raw = {bus.sense_10, bus.sense_5};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      rise   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        rise[i] <= 1'b0;
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == DEB_LAST) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
            rise[i]   <= sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // The last gap cycle doubles as an IDLE decision so exactly GAP_CYCLES zero cycles separate coins.
  assign can_issue = (state == IDLE) || (state == GAP && gap_cnt == '0) ||
                     (state == ISSUE && GAP_CYCLES == 0);
  assign pop       = can_issue && (count != '0) && !bus.hold;
  assign full_now  = (count == DEPTH_N) && !pop;
  assign both      = &rise;
  assign single    = ^rise;
  assign push      = single && !full_now;
  assign push_code = rise[0] ? 2'b01 : 2'b10;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      gap_cnt    <= '0;
      coin_q     <= 2'b00;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      reject_q   <= both || (single && full_now);
      overflow_q <= single && full_now;

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + NW'(push) - NW'(pop);

      if (pop) begin
        coin_q <= mem[rd_ptr];
        state  <= ISSUE;
      end else begin
        coin_q <= 2'b00;
        case (state)
          ISSUE: begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end
          GAP: begin
            if (gap_cnt == '0)
              state <= IDLE;
            else
              gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.coin      = coin_q;
  assign bus.reject    = reject_q;
  assign bus.overflow  = overflow_q;
  assign bus.fifo_full = (count == DEPTH_N);

endmodule
